// File: rtl/dlt_sig_adc_decimator.sv
// dlt_sig_adc_decimator
// Recovers 16-bit signed PCM from a 1-bit delta-sigma / PDM bitstream using a
// second-order CIC decimator (ratio R = 2**LOG2_DECIM) followed by an
// arithmetic-shift scaler with saturation to the 16-bit signed range.
//
// Pipeline, with t the cycle in which the R-th bit of a period is accepted:
//   t   : integrators absorb the bit, dec_stb is registered
//   t+1 : comb 1 (C1 <- I2 - I2_d)
//   t+2 : comb 2 (Y  <- C1 - C1_d), sample_valid registered
//   t+3 : sample_out (scaled/saturated Y) and sample_valid presented
module dlt_sig_adc_decimator #(
  parameter int LOG2_DECIM = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] sample_out,
  output logic        sample_valid
);

  // Internal width: a second-order CIC grows by 2*log2(R) bits over the
  // 1-bit (+/-1) input, plus a sign bit and one bit of headroom so that
  // the peak |Y| = R**2 stays representable.
  localparam int W     = 2 * LOG2_DECIM + 2;
  // Y spans +/-R**2 = +/-2**(2*LOG2_DECIM); this shift maps it onto +/-2**15.
  localparam int SHIFT = 2 * LOG2_DECIM - 15;

  localparam logic [LOG2_DECIM-1:0] DCNT_LAST = '1;
  localparam logic signed [W-1:0]   SAT_HI    = W'(32767);
  localparam logic signed [W-1:0]   SAT_LO    = W'(-32768);

  // Integrator section (runs at the bit rate, gated by bit_valid)
  logic [W-1:0]          i1_q, i1_d;
  logic [W-1:0]          i2_q, i2_d;
  logic [W-1:0]          step;
  logic [LOG2_DECIM-1:0] dcnt_q, dcnt_d;
  logic                  dec_stb_q, dec_stb_d;

  // Comb section (runs once per decimation period)
  logic [W-1:0]          i2_dly_q, i2_dly_d;
  logic [W-1:0]          c1_q, c1_d;
  logic [W-1:0]          c1_dly_q, c1_dly_d;
  logic                  comb2_stb_q, comb2_stb_d;
  logic signed [W-1:0]   y_q, y_d;

  // Output / warm-up control
  logic [1:0]            warm_q, warm_d;
  logic                  sample_valid_q, sample_valid_d;
  logic signed [W-1:0]   scaled;
  logic [15:0]           sample_sat;

  // Map the bit to +1/-1 in W-bit two's complement: 0...01 or 1...11.
  assign step = {{(W-1){~bit_in}}, 1'b1};

  // Integrators and decimation counter advance only on accepted bits; I2
  // deliberately adds the pre-update I1. dec_stb fires after the R-th bit.
  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    dcnt_d    = dcnt_q;
    dec_stb_d = 1'b0;
    if (bit_valid) begin
      i1_d      = i1_q + step;
      i2_d      = i2_q + i1_q;
      dcnt_d    = dcnt_q + LOG2_DECIM'(1);
      dec_stb_d = (dcnt_q == DCNT_LAST);
    end
  end

  // First comb differences successive I2 snapshots on the decimation strobe.
  always_comb begin
    i2_dly_d    = i2_dly_q;
    c1_d        = c1_q;
    comb2_stb_d = dec_stb_q;
    if (dec_stb_q) begin
      c1_d     = i2_q - i2_dly_q;
      i2_dly_d = i2_q;
    end
  end

  // Second comb one cycle later; the warm-up counter hides the first two
  // outputs, which still carry the combs' zero-initialised history.
  always_comb begin
    c1_dly_d       = c1_dly_q;
    y_d            = y_q;
    warm_d         = warm_q;
    sample_valid_d = 1'b0;
    if (comb2_stb_q) begin
      y_d      = $signed(c1_q - c1_dly_q);
      c1_dly_d = c1_q;
      if (warm_q == 2'd2) begin
        sample_valid_d = 1'b1;
      end else begin
        warm_d = warm_q + 2'd1;
      end
    end
  end

  // Scale Y down to 16 bits and clamp; Y is a register, so sample_out
  // changes only when a new comb result lands and holds in between.
  always_comb begin
    scaled = y_q >>> SHIFT;
    if (scaled > SAT_HI) begin
      sample_sat = 16'h7FFF;
    end else if (scaled < SAT_LO) begin
      sample_sat = 16'h8000;
    end else begin
      sample_sat = scaled[15:0];
    end
  end

  assign sample_out   = sample_sat;
  assign sample_valid = sample_valid_q;

  // State registers; reset clears everything, dropping any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q           <= '0;
      i2_q           <= '0;
      dcnt_q         <= '0;
      dec_stb_q      <= 1'b0;
      i2_dly_q       <= '0;
      c1_q           <= '0;
      c1_dly_q       <= '0;
      comb2_stb_q    <= 1'b0;
      y_q            <= '0;
      warm_q         <= 2'd0;
      sample_valid_q <= 1'b0;
    end else begin
      i1_q           <= i1_d;
      i2_q           <= i2_d;
      dcnt_q         <= dcnt_d;
      dec_stb_q      <= dec_stb_d;
      i2_dly_q       <= i2_dly_d;
      c1_q           <= c1_d;
      c1_dly_q       <= c1_dly_d;
      comb2_stb_q    <= comb2_stb_d;
      y_q            <= y_d;
      warm_q         <= warm_d;
      sample_valid_q <= sample_valid_d;
    end
  end

endmodule
